// File: rtl/add_mult_accum_pkg.sv
// Shared types and defaults for the add/mult accumulator: FSM state encoding,
// default array geometry and the adder-tree depth helper.
package add_mult_accum_pkg;

    localparam int NUM_PROD_DEFAULT = 12;
    localparam int PROD_W_DEFAULT   = 18;
    // Growth bits on the beat sum; covers up to 16 product terms.
    localparam int SUM_GUARD        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of pairwise adder levels needed to reduce n terms to one.
    function automatic int tree_levels(input int n);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < n) begin
            span = span << 1;
            lv   = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/add_mult_accum_sum_tree.sv
// Combinational signed adder tree: reduces NUM_PROD product terms to one
// sign-extended sum, zero-padding up to the next power of two.
module prod_sum_tree
    import add_mult_accum_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEFAULT,
    parameter int NUM_PROD = NUM_PROD_DEFAULT,
    parameter int SUM_W    = PROD_W + SUM_GUARD
) (
    input  logic signed [PROD_W-1:0] prod_i [0:NUM_PROD-1],
    output logic signed [SUM_W-1:0]  sum_o
);

    localparam int LEVELS = tree_levels(NUM_PROD);
    localparam int LEAVES = 1 << LEVELS;

    genvar gl;
    genvar gi;
    generate
        for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
            logic signed [SUM_W-1:0] node [0:(LEAVES >> gl)-1];

            if (gl == 0) begin : g_leaf
                for (gi = 0; gi < LEAVES; gi++) begin : g_term
                    if (gi < NUM_PROD) begin : g_prod
                        assign node[gi] = SUM_W'(prod_i[gi]);
                    end else begin : g_pad
                        assign node[gi] = '0;
                    end
                end
            end else begin : g_add
                for (gi = 0; gi < (LEAVES >> gl); gi++) begin : g_pair
                    assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
                end
            end
        end
    endgenerate

    assign sum_o = g_lvl[LEVELS].node[0];

endmodule

// File: rtl/add_mult_accum.sv
// Dot-product accumulator: sums a beat of product terms (stage 1), accumulates
// beats (stage 2), and returns accumulator minus a correction term per job.
module add_mult_accum
    import add_mult_accum_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEFAULT,
    parameter int NUM_PROD = NUM_PROD_DEFAULT,
    parameter int ACC_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [15:0]              len_i,
    input  logic signed [ACC_W-1:0]  corr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [PROD_W-1:0] prod_i [0:NUM_PROD-1],
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [ACC_W-1:0]  out_data_o,
    output logic                     busy_o
);

    localparam int SUM_W = PROD_W + SUM_GUARD;

    state_t                  state_reg;
    state_t                  state_next;
    logic [15:0]             len_reg;
    logic [15:0]             cnt_reg;
    logic signed [ACC_W-1:0] corr_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] out_data_reg;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [SUM_W-1:0] s1_sum_reg;
    logic                    s1_valid_reg;
    logic                    accept;
    logic                    last_beat;

    prod_sum_tree #(
        .PROD_W   (PROD_W),
        .NUM_PROD (NUM_PROD),
        .SUM_W    (SUM_W)
    ) u_tree (
        .prod_i (prod_i),
        .sum_o  (tree_sum)
    );

    assign accept    = in_valid_i && in_ready_o;
    assign last_beat = accept && (cnt_reg == len_reg - 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            // The last beat's sum must reach the accumulator before the result is formed.
            DRAIN: begin
                if (!s1_valid_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_reg == RUN);
        out_valid_o = (state_reg == DONE);
        busy_o      = (state_reg != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_reg      <= '0;
            cnt_reg      <= '0;
            corr_reg     <= '0;
            acc_reg      <= '0;
            out_data_reg <= '0;
            s1_sum_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sum_reg <= tree_sum;
                cnt_reg    <= cnt_reg + 16'd1;
            end
            if (s1_valid_reg) begin
                acc_reg <= acc_reg + ACC_W'(s1_sum_reg);
            end
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == 16'd0) begin
                            out_data_reg <= -corr_i;
                        end else begin
                            len_reg  <= len_i;
                            corr_reg <= corr_i;
                            cnt_reg  <= '0;
                            acc_reg  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid_reg) begin
                        out_data_reg <= acc_reg - corr_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data_o = out_data_reg;

endmodule

// File: doc/add_mult_accum.md
ADD_MULT_ACCUM -- requirements
Module: add_mult_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 18, width of each signed product term from the add/mult array.
REQ-002 SHALL have parameter NUM_PROD, default 12, number of product terms per beat.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator and result width; must be at least PROD_W+4.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, single-cycle pulse that starts a dot-product job.
REQ-007 SHALL have port len_i, input, 16, number of beats in the job; sampled on start_i.
REQ-008 SHALL have port corr_i, input, ACC_W, signed correction term; sampled on start_i.
REQ-009 SHALL have port in_valid_i, input, 1, product beat valid.
REQ-010 SHALL have port in_ready_o, output, 1, block accepts a product beat.
REQ-011 SHALL have port prod_i, input, NUM_PROD x PROD_W unpacked array [0:NUM_PROD-1], signed product terms.
REQ-012 SHALL have port out_valid_o, output, 1, result valid.
REQ-013 SHALL have port out_ready_i, input, 1, consumer accepts the result.
REQ-014 SHALL have port out_data_o, output, ACC_W, signed result.
REQ-015 SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 In IDLE, start_i with len_i!=0 SHALL latch len_i and corr_i, clear the beat counter and accumulator, and enter RUN.
REQ-018 In IDLE, start_i with len_i==0 SHALL set out_data_o to -corr_i and enter DONE on the next cycle.
REQ-019 SHALL ignore start_i in RUN, DRAIN and DONE.
REQ-020 SHALL drive in_ready_o high only in RUN; a beat is accepted on in_valid_i && in_ready_o.
REQ-021 Stage 1 SHALL register the sign-extended sum of all NUM_PROD terms of an accepted beat (width PROD_W+4) together with a valid flag.
REQ-022 Stage 2 SHALL add the sign-extended stage-1 sum into the accumulator in the cycle after stage 1 holds a valid sum.
REQ-023 The accumulator SHALL wrap modulo 2^ACC_W without saturation.
REQ-024 On acceptance of beat number len, the FSM SHALL leave RUN for DRAIN, with in_ready_o low from the next cycle.
REQ-025 DRAIN SHALL wait until the stage-1 valid flag is clear, then load out_data_o with accumulator minus latched corr_i and enter DONE.
REQ-026 out_valid_o SHALL rise exactly 3 cycles after the cycle in which the last beat is accepted.
REQ-027 In DONE, out_valid_o SHALL be high and out_data_o SHALL be stable until out_ready_i is high, then the FSM enters IDLE on the next cycle.
REQ-028 Gaps in in_valid_i during RUN SHALL stall counting without affecting the result.

Reset
REQ-029 While rst_ni is low, the block SHALL be in IDLE with the accumulator, counter, stage-1 register and flag cleared, in_ready_o=0, out_valid_o=0, out_data_o=0 and busy_o=0.
REQ-030 Reset asserted mid-job SHALL abort the job with no partial result emitted.

Structure
REQ-031 Package add_mult_accum_pkg SHALL hold the FSM state enum and the default constants NUM_PROD=12 and PROD_W=18.
REQ-032 The NUM_PROD-input signed adder tree SHALL be one sub-module, prod_sum_tree, which is combinational; stage 1 registers its output.

Verification
REQ-033 Bench SHALL check: len=1, all prod=1, corr=0 -> out_data=12, with out_valid 3 cycles after the accepted beat.
REQ-034 Bench SHALL check: len=4, all prod=-1, corr=5 -> out_data=-53.
REQ-035 Bench SHALL check: len=3, all prod=131071, in_valid toggling 1-0-1-0-1 -> out_data=4718556.
REQ-036 Bench SHALL check: len=0, corr=7 -> out_valid on the next cycle with out_data=-7, and in_ready never high.
REQ-037 Bench SHALL check: out_ready held low for 5 cycles in DONE -> out_data stable, and start_i pulses during DONE are ignored.
REQ-038 Bench SHALL check: rst_ni pulsed low after 2 of 4 beats -> all outputs 0, then a fresh len=1 job gives the correct result.
